hamming_tx_ctrl: RTL and testbench
==================================

Name: hamming_tx_ctrl

Overview:
Sequences the shared Hamming(8,4) encoder for the UART transmit path. Accepts one data byte per valid/ready handshake and presents its two nibbles to the encoder one at a time. Captures each 8-bit code word and launches it to the UART transmitter with a start/busy handshake. Keeps a transmitted-byte counter and a sticky timeout flag.

Parameters:
LOW_FIRST, 1, 1: low nibble encoded/sent first; 0: high nibble first
CNT_W, 16, width of byte_cnt
BUSY_TIMEOUT, 16, max cycles waiting for tx_busy to rise after tx_start (must be >= 2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_data  in  8  byte to transmit
in_valid  in  1  in_data valid
in_ready  out  1  controller can accept a byte
enc_nibble  out  4  nibble to encoder data_in (D3..D0)
enc_code  in  8  encoder code_out {P1,P2,D3,P4,D2,D1,D0,P8}, combinational from enc_nibble
tx_data  out  8  code word to UART TX, registered
tx_start  out  1  one-cycle start pulse to UART TX
tx_busy  in  1  UART TX busy
busy  out  1  controller not in IDLE
byte_cnt  out  CNT_W  bytes fully sent, wraps
tx_timeout  out  1  sticky: tx_busy never rose after a start

Behaviour:
- Clock is clk; reset is asynchronous, active-low on rst_n. Every output is 0 during reset: in_ready, enc_nibble, tx_data, tx_start, busy, byte_cnt, tx_timeout. State returns to IDLE.
- States: IDLE, SEND_A, WAIT_A, SEND_B, WAIT_B.
- IDLE: in_ready=1, busy=0, enc_nibble=0. On in_valid&&in_ready, latch in_data into hold_reg and go to SEND_A. No other state accepts a byte.
- enc_nibble: in SEND_A/WAIT_A it is the first nibble (hold_reg[3:0] if LOW_FIRST=1, else [7:4]). In SEND_B/WAIT_B it is the other nibble.
- SEND_x: if tx_busy=0, register tx_data<=enc_code, pulse tx_start for exactly 1 cycle, clear the wait counter and seen_busy, then go to WAIT_x. If tx_busy=1, stay with no pulse.
- WAIT_x:
  - seen_busy sets when tx_busy=1.
  - Leave when seen_busy=1 and tx_busy=0: WAIT_A goes to SEND_B; WAIT_B goes to IDLE and increments byte_cnt.
  - If seen_busy=0 after BUSY_TIMEOUT cycles, set tx_timeout and leave as if complete.
- Latency: first tx_start occurs 1 cycle after acceptance if tx_busy=0. The second tx_start is no earlier than 1 cycle after WAIT_A exits.
- tx_data holds its value between starts. tx_start is never high on two consecutive cycles.
- byte_cnt wraps from 2^CNT_W-1 to 0. tx_timeout clears only on reset.
- Reset mid-operation: the byte is dropped and no further tx_start is issued.
- in_valid changes while not in IDLE are ignored; hold_reg is stable until return to IDLE.

Optional Feature:
HAMMING_ERR_INJ_EN:
- Defined: adds inputs inj_en (1) and inj_pos (3). inj_en is sampled at byte acceptance. If it was 1, the first code word of that byte is sent as enc_code ^ (8'h80 >> inj_pos), where inj_pos=0 flips P1 and 7 flips P8. The second code word is unaltered.
- Undefined: these ports do not exist and tx_data always equals enc_code.

Test Plan:
- Reset with rst_n=0 mid-WAIT_A -> all outputs 0 immediately; after release in_ready=1 and no tx_start.
- LOW_FIRST=1, send 0xA5, UART model raising busy 1 cycle after start for 10 cycles -> tx_data 0x9A then 0x65, two single-cycle pulses, byte_cnt=1, in_ready=1 after.
- LOW_FIRST=0, send 0xA5 -> order 0x65 then 0x9A.
- Hold tx_busy=1 entering SEND_A -> no tx_start until busy drops; tx_busy never rising after start -> tx_timeout=1 after BUSY_TIMEOUT cycles, byte still completes, byte_cnt increments.
- Back-to-back in_valid=1 with 0x00, 0xFF -> code words 0x00, 0x00, 0xFF, 0xFF; in_ready low during transfer; byte_cnt=2.
- HAMMING_ERR_INJ_EN defined, inj_en=1, inj_pos=7, byte 0xA5 -> 0x9B then 0x65.

Source files
------------

// File: rtl/hamming_tx_ctrl_if.sv
// -----------------------------------------------------------------------------
// hamming_tx_ctrl_if
// Bundles the byte-input handshake, the shared Hamming encoder hook-up and the
// UART transmitter handshake used by hamming_tx_ctrl.
//   in_data/in_valid/in_ready : byte source handshake
//   enc_nibble/enc_code       : nibble to the encoder, code word back (comb.)
//   tx_data/tx_start/tx_busy  : code word launch to the UART transmitter
// Modports: slave  = the controller itself
//           master = the surrounding system (source, encoder, UART)
// -----------------------------------------------------------------------------
interface hamming_tx_ctrl_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] enc_nibble;
   logic [7:0] enc_code;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_busy;

   modport master (
      output in_data, in_valid, enc_code, tx_busy,
      input  in_ready, enc_nibble, tx_data, tx_start
   );

   modport slave (
      input  in_data, in_valid, enc_code, tx_busy,
      output in_ready, enc_nibble, tx_data, tx_start
   );
endinterface

// File: rtl/hamming_tx_ctrl.sv
// -----------------------------------------------------------------------------
// hamming_tx_ctrl
// Sequences the shared Hamming(8,4) encoder for the UART transmit path. One
// byte is accepted per handshake; its two nibbles are encoded one after the
// other and each resulting code word is launched to the UART with a one-cycle
// start pulse, waiting for the transmitter's busy to rise and fall in between.
//
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   bus (slave) : in_data/in_valid/in_ready, enc_nibble/enc_code,
//                 tx_data/tx_start/tx_busy
//   busy        : controller not idle
//   byte_cnt    : bytes fully sent (wraps)
//   tx_timeout  : sticky, tx_busy never rose after some start
//   inj_en, inj_pos (only with HAMMING_ERR_INJ_EN): flip one bit of the
//                 first code word of a byte, sampled at byte acceptance
//
// Optional feature macro: HAMMING_ERR_INJ_EN
// -----------------------------------------------------------------------------
module hamming_tx_ctrl #(
   parameter int LOW_FIRST    = 1,
   parameter int CNT_W        = 16,
   parameter int BUSY_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   hamming_tx_ctrl_if.slave bus,
`ifdef HAMMING_ERR_INJ_EN
   input  logic             inj_en,
   input  logic [2:0]       inj_pos,
`endif
   output logic             busy,
   output logic [CNT_W-1:0] byte_cnt,
   output logic             tx_timeout
);

   localparam int TW = $clog2(BUSY_TIMEOUT + 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SEND_A = 3'd1;
   localparam logic [2:0] S_WAIT_A = 3'd2;
   localparam logic [2:0] S_SEND_B = 3'd3;
   localparam logic [2:0] S_WAIT_B = 3'd4;

   logic [2:0]       r_state;
   logic             r_live;
   logic [7:0]       r_hold;
   logic [7:0]       r_tx_data;
   logic             r_tx_start;
   logic [TW-1:0]    r_wait_cnt;
   logic             r_seen_busy;
   logic [CNT_W-1:0] r_byte_cnt;
   logic             r_timeout;

   logic             w_idle;
   logic             w_accept;
   logic             w_done;
   logic             w_tmo;
   logic [3:0]       w_first;
   logic [3:0]       w_second;
   logic [3:0]       w_nibble;
   logic [7:0]       w_inj_mask;

   // in_ready is qualified by r_live so it stays low while reset is held,
   // even though the state register already sits in IDLE.
   assign w_idle   = (r_state == S_IDLE);
   assign w_accept = w_idle && r_live && bus.in_valid;

   assign w_first  = (LOW_FIRST != 0) ? r_hold[3:0] : r_hold[7:4];
   assign w_second = (LOW_FIRST != 0) ? r_hold[7:4] : r_hold[3:0];

   always_comb begin
      w_nibble = 4'h0;
      case (r_state)
         S_SEND_A, S_WAIT_A: w_nibble = w_first;
         S_SEND_B, S_WAIT_B: w_nibble = w_second;
         default:            w_nibble = 4'h0;
      endcase
   end

   // Normal completion needs busy to have been seen and then dropped; the
   // timeout only fires if busy never showed up within the window.
   assign w_done = r_seen_busy && !bus.tx_busy;
   assign w_tmo  = !r_seen_busy && !bus.tx_busy &&
                   (r_wait_cnt == TW'(BUSY_TIMEOUT - 1));

`ifdef HAMMING_ERR_INJ_EN
   logic [7:0] r_inj_mask;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inj_mask <= 8'h00;
      end else if (w_accept) begin
         r_inj_mask <= inj_en ? (8'h80 >> inj_pos) : 8'h00;
      end
   end

   assign w_inj_mask = r_inj_mask;
`else
   assign w_inj_mask = 8'h00;
`endif

   // Data byte holding register: only loaded on acceptance, never reset.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_hold <= bus.in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_live      <= 1'b0;
         r_tx_data   <= 8'h00;
         r_tx_start  <= 1'b0;
         r_wait_cnt  <= '0;
         r_seen_busy <= 1'b0;
         r_byte_cnt  <= '0;
         r_timeout   <= 1'b0;
      end else begin
         r_live     <= 1'b1;
         r_tx_start <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state <= S_SEND_A;
               end
            end
            S_SEND_A, S_SEND_B: begin
               if (!bus.tx_busy) begin
                  r_tx_data   <= bus.enc_code ^
                                 ((r_state == S_SEND_A) ? w_inj_mask : 8'h00);
                  r_tx_start  <= 1'b1;
                  r_wait_cnt  <= '0;
                  r_seen_busy <= 1'b0;
                  r_state     <= (r_state == S_SEND_A) ? S_WAIT_A : S_WAIT_B;
               end
            end
            S_WAIT_A, S_WAIT_B: begin
               if (bus.tx_busy) begin
                  r_seen_busy <= 1'b1;
               end
               // Counter only matters until busy is seen; freezing it then
               // keeps it from wrapping during long transmissions.
               if (!r_seen_busy) begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
               if (w_done || w_tmo) begin
                  if (w_tmo) begin
                     r_timeout <= 1'b1;
                  end
                  if (r_state == S_WAIT_A) begin
                     r_state <= S_SEND_B;
                  end else begin
                     r_state    <= S_IDLE;
                     r_byte_cnt <= r_byte_cnt + 1'b1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready   = w_idle && r_live;
   assign bus.enc_nibble = w_nibble;
   assign bus.tx_data    = r_tx_data;
   assign bus.tx_start   = r_tx_start;
   assign busy           = !w_idle;
   assign byte_cnt       = r_byte_cnt;
   assign tx_timeout     = r_timeout;

endmodule

// File: tb/tb_hamming_tx_ctrl.sv
`timescale 1ns/1ps
module tb_hamming_tx_ctrl;

   localparam int BT = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hamming_tx_ctrl_if b1();
   hamming_tx_ctrl_if b0();

   logic        busy1, tmo1, busy0, tmo0;
   logic [15:0] cnt1;
   logic [1:0]  cnt0;
`ifdef HAMMING_ERR_INJ_EN
   logic        inj_en = 1'b0;
   logic [2:0]  inj_pos = 3'd0;
`endif

   hamming_tx_ctrl #(.LOW_FIRST(1), .CNT_W(16), .BUSY_TIMEOUT(BT)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(b1),
`ifdef HAMMING_ERR_INJ_EN
      .inj_en(inj_en), .inj_pos(inj_pos),
`endif
      .busy(busy1), .byte_cnt(cnt1), .tx_timeout(tmo1));

   hamming_tx_ctrl #(.LOW_FIRST(0), .CNT_W(2), .BUSY_TIMEOUT(BT)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(b0),
`ifdef HAMMING_ERR_INJ_EN
      .inj_en(1'b0), .inj_pos(3'd0),
`endif
      .busy(busy0), .byte_cnt(cnt0), .tx_timeout(tmo0));

   // Hamming(8,4) encoder, code word layout {P1,P2,D3,P4,D2,D1,D0,P8}
   function automatic logic [7:0] ham(input logic [3:0] d);
      logic p1, p2, p4, p8;
      p1 = d[3] ^ d[1] ^ d[0];
      p2 = d[3] ^ d[2] ^ d[0];
      p4 = d[3] ^ d[2] ^ d[1];
      p8 = ^{p1, p2, p4, d};
      return {p1, p2, d[3], p4, d[2], d[1], d[0], p8};
   endfunction

   assign b1.enc_code = ham(b1.enc_nibble);
   assign b0.enc_code = ham(b0.enc_nibble);

   // UART models: busy rises the cycle after a start and lasts ulen cycles
   int   ulen = 10;
   bit   dead = 1'b0;
   bit   hold = 1'b0;
   logic ub1, ub0;
   int   uc1, uc0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ub1 <= 1'b0; uc1 <= 0;
      end else if (b1.tx_start && !dead) begin
         ub1 <= 1'b1; uc1 <= ulen - 1;
      end else if (ub1) begin
         if (uc1 == 0) ub1 <= 1'b0;
         else          uc1 <= uc1 - 1;
      end
   end
   assign b1.tx_busy = ub1 | hold;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ub0 <= 1'b0; uc0 <= 0;
      end else if (b0.tx_start) begin
         ub0 <= 1'b1; uc0 <= 2;
      end else if (ub0) begin
         if (uc0 == 0) ub0 <= 1'b0;
         else          uc0 <= uc0 - 1;
      end
   end
   assign b0.tx_busy = ub0;

   // Reference model state and observation queues
   logic [7:0] exp1[$], obs1[$], exp0[$], obs0[$];
   int cnt1_exp = 0, cnt0_exp = 0;
   int starts1 = 0, dbl1 = 0, starts0 = 0, dbl0 = 0;
   int tests = 0, fails = 0;

   initial begin
      logic p1, p0;
      p1 = 1'b0; p0 = 1'b0;
      forever begin
         @(negedge clk);
         if (b1.tx_start === 1'b1) begin
            obs1.push_back(b1.tx_data); starts1++;
            if (p1) dbl1++;
         end
         if (b0.tx_start === 1'b1) begin
            obs0.push_back(b0.tx_data); starts0++;
            if (p0) dbl0++;
         end
         p1 = (b1.tx_start === 1'b1);
         p0 = (b0.tx_start === 1'b1);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Called at a negedge; returns at the negedge after the accepting posedge.
   task automatic send1(input logic [7:0] d, input logic [7:0] mask, input bit keep);
      int n = 0;
      b1.in_data = d; b1.in_valid = 1'b1;
      while (b1.in_ready !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
      tests++;
      if (b1.in_ready !== 1'b1) begin
         fails++; $display("FAIL send1_ready: in_ready=%b required 1", b1.in_ready);
      end
      exp1.push_back(ham(d[3:0]) ^ mask);
      exp1.push_back(ham(d[7:4]));
      cnt1_exp++;
      @(posedge clk);
      @(negedge clk);
      if (!keep) b1.in_valid = 1'b0;
   endtask

   task automatic send0(input logic [7:0] d);
      int n = 0;
      b0.in_data = d; b0.in_valid = 1'b1;
      while (b0.in_ready !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
      tests++;
      if (b0.in_ready !== 1'b1) begin
         fails++; $display("FAIL send0_ready: in_ready=%b required 1", b0.in_ready);
      end
      exp0.push_back(ham(d[7:4]));
      exp0.push_back(ham(d[3:0]));
      cnt0_exp++;
      @(posedge clk);
      @(negedge clk);
      b0.in_valid = 1'b0;
   endtask

   task automatic wait_idle1();
      int n = 0;
      while (busy1 !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
      tests++;
      if (busy1 !== 1'b0) begin
         fails++; $display("FAIL idle1: busy=%b required 0 within budget", busy1);
      end
   endtask

   task automatic wait_idle0();
      int n = 0;
      while (busy0 !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
      tests++;
      if (busy0 !== 1'b0) begin
         fails++; $display("FAIL idle0: busy=%b required 0 within budget", busy0);
      end
   endtask

   task automatic test_reset();
      b1.in_valid = 1'b0; b1.in_data = 8'h00;
      b0.in_valid = 1'b0; b0.in_data = 8'h00;
      repeat (3) @(negedge clk);
      tests++;
      if ({b1.in_ready, b1.enc_nibble, b1.tx_data, b1.tx_start, busy1, tmo1, cnt1} !== '0) begin
         fails++; $display("FAIL reset_outs1: got %h required 0",
            {b1.in_ready, b1.enc_nibble, b1.tx_data, b1.tx_start, busy1, tmo1, cnt1});
      end
      tests++;
      if ({b0.in_ready, b0.enc_nibble, b0.tx_data, b0.tx_start, busy0, tmo0, cnt0} !== '0) begin
         fails++; $display("FAIL reset_outs0: got %h required 0",
            {b0.in_ready, b0.enc_nibble, b0.tx_data, b0.tx_start, busy0, tmo0, cnt0});
      end
      rst_n = 1'b1;
      @(negedge clk);
      tests++;
      if (b1.in_ready !== 1'b1 || busy1 !== 1'b0) begin
         fails++; $display("FAIL reset_release: in_ready=%b busy=%b required 1/0", b1.in_ready, busy1);
      end
   endtask

   task automatic test_basic_a5();
      ulen = 10;
      send1(8'hA5, 8'h00, 1'b0);
      tests++;
      if (b1.in_ready !== 1'b0 || busy1 !== 1'b1) begin
         fails++; $display("FAIL basic_busy: in_ready=%b busy=%b required 0/1", b1.in_ready, busy1);
      end
      @(negedge clk);
      tests++;
      if (b1.tx_start !== 1'b1 || b1.tx_data !== ham(4'h5)) begin
         fails++; $display("FAIL basic_latency: start=%b data=%h required 1/%h", b1.tx_start, b1.tx_data, ham(4'h5));
      end
      wait_idle1();
      tests++;
      if (obs1.size() != 2 || exp1.size() != 2) begin
         fails++; $display("FAIL basic_words: got %0d words required 2", obs1.size());
      end
      for (int i = 0; i < obs1.size() && i < exp1.size(); i++) begin
         tests++;
         if (obs1[i] !== exp1[i]) begin
            fails++; $display("FAIL basic_word%0d: got %h required %h", i, obs1[i], exp1[i]);
         end
      end
      obs1.delete(); exp1.delete();
      tests++;
      if (cnt1 !== 16'(cnt1_exp) || b1.in_ready !== 1'b1) begin
         fails++; $display("FAIL basic_cnt: byte_cnt=%0d in_ready=%b required %0d/1", cnt1, b1.in_ready, cnt1_exp);
      end
   endtask

   task automatic test_high_first();
      send0(8'hA5);
      wait_idle0();
      tests++;
      if (obs0.size() != 2) begin
         fails++; $display("FAIL hf_words: got %0d words required 2", obs0.size());
      end
      for (int i = 0; i < obs0.size() && i < exp0.size(); i++) begin
         tests++;
         if (obs0[i] !== exp0[i]) begin
            fails++; $display("FAIL hf_word%0d: got %h required %h", i, obs0[i], exp0[i]);
         end
      end
      obs0.delete(); exp0.delete();
   endtask

   task automatic test_wrap();
      for (int k = 0; k < 3; k++) begin
         send0(8'($urandom));
         wait_idle0();
      end
      for (int i = 0; i < obs0.size() && i < exp0.size(); i++) begin
         tests++;
         if (obs0[i] !== exp0[i]) begin
            fails++; $display("FAIL wrap_word%0d: got %h required %h", i, obs0[i], exp0[i]);
         end
      end
      tests++;
      if (obs0.size() != 6) begin
         fails++; $display("FAIL wrap_words: got %0d words required 6", obs0.size());
      end
      obs0.delete(); exp0.delete();
      tests++;
      if (cnt0 !== 2'(cnt0_exp % 4)) begin
         fails++; $display("FAIL wrap_cnt: byte_cnt=%0d required %0d", cnt0, cnt0_exp % 4);
      end
   endtask

   task automatic test_busy_hold();
      int s;
      ulen = 3; hold = 1'b1;
      send1(8'h3C, 8'h00, 1'b0);
      s = starts1;
      repeat (6) @(negedge clk);
      tests++;
      if (starts1 != s || busy1 !== 1'b1) begin
         fails++; $display("FAIL hold_nostart: starts=%0d busy=%b required %0d/1", starts1, busy1, s);
      end
      hold = 1'b0;
      wait_idle1();
      for (int i = 0; i < obs1.size() && i < exp1.size(); i++) begin
         tests++;
         if (obs1[i] !== exp1[i]) begin
            fails++; $display("FAIL hold_word%0d: got %h required %h", i, obs1[i], exp1[i]);
         end
      end
      tests++;
      if (obs1.size() != 2 || cnt1 !== 16'(cnt1_exp)) begin
         fails++; $display("FAIL hold_done: words=%0d byte_cnt=%0d required 2/%0d", obs1.size(), cnt1, cnt1_exp);
      end
      obs1.delete(); exp1.delete();
   endtask

   task automatic test_back_to_back();
      ulen = 2;
      send1(8'h00, 8'h00, 1'b1);
      tests++;
      if (b1.in_ready !== 1'b0) begin
         fails++; $display("FAIL b2b_ready: in_ready=%b required 0", b1.in_ready);
      end
      send1(8'hFF, 8'h00, 1'b0);
      tests++;
      if (b1.in_ready !== 1'b0) begin
         fails++; $display("FAIL b2b_ready2: in_ready=%b required 0", b1.in_ready);
      end
      wait_idle1();
      tests++;
      if (obs1.size() != 4) begin
         fails++; $display("FAIL b2b_words: got %0d words required 4", obs1.size());
      end
      for (int i = 0; i < obs1.size() && i < exp1.size(); i++) begin
         tests++;
         if (obs1[i] !== exp1[i]) begin
            fails++; $display("FAIL b2b_word%0d: got %h required %h", i, obs1[i], exp1[i]);
         end
      end
      obs1.delete(); exp1.delete();
      tests++;
      if (cnt1 !== 16'(cnt1_exp)) begin
         fails++; $display("FAIL b2b_cnt: byte_cnt=%0d required %0d", cnt1, cnt1_exp);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 16; k++) begin
         ulen = $urandom_range(1, 6);
         send1(8'($urandom), 8'h00, 1'b0);
         wait_idle1();
      end
      tests++;
      if (obs1.size() != exp1.size()) begin
         fails++; $display("FAIL rand_words: got %0d words required %0d", obs1.size(), exp1.size());
      end
      for (int i = 0; i < obs1.size() && i < exp1.size(); i++) begin
         tests++;
         if (obs1[i] !== exp1[i]) begin
            fails++; $display("FAIL rand_word%0d: got %h required %h", i, obs1[i], exp1[i]);
         end
      end
      obs1.delete(); exp1.delete();
      tests++;
      if (cnt1 !== 16'(cnt1_exp) || tmo1 !== 1'b0) begin
         fails++; $display("FAIL rand_cnt: byte_cnt=%0d timeout=%b required %0d/0", cnt1, tmo1, cnt1_exp);
      end
   endtask

   task automatic test_timeout();
      dead = 1'b1;
      send1(8'($urandom), 8'h00, 1'b0);
      wait_idle1();
      dead = 1'b0;
      tests++;
      if (tmo1 !== 1'b1 || cnt1 !== 16'(cnt1_exp)) begin
         fails++; $display("FAIL tmo_flag: timeout=%b byte_cnt=%0d required 1/%0d", tmo1, cnt1, cnt1_exp);
      end
      tests++;
      if (obs1.size() != 2) begin
         fails++; $display("FAIL tmo_words: got %0d words required 2", obs1.size());
      end
      obs1.delete(); exp1.delete();
      ulen = 2;
      send1(8'h5A, 8'h00, 1'b0);
      wait_idle1();
      obs1.delete(); exp1.delete();
      tests++;
      if (tmo1 !== 1'b1) begin
         fails++; $display("FAIL tmo_sticky: timeout=%b required 1", tmo1);
      end
   endtask

`ifdef HAMMING_ERR_INJ_EN
   task automatic test_inject();
      ulen = 3;
      inj_en = 1'b1; inj_pos = 3'd7;
      send1(8'hA5, 8'(1 << (7 - 7)), 1'b0);
      inj_en = 1'b0;
      wait_idle1();
      for (int i = 0; i < obs1.size() && i < exp1.size(); i++) begin
         tests++;
         if (obs1[i] !== exp1[i]) begin
            fails++; $display("FAIL inj_word%0d: got %h required %h", i, obs1[i], exp1[i]);
         end
      end
      tests++;
      if (obs1.size() != 2) begin
         fails++; $display("FAIL inj_words: got %0d words required 2", obs1.size());
      end
      obs1.delete(); exp1.delete();
   endtask
`endif

   task automatic test_reset_mid();
      int s;
      ulen = 10;
      send1(8'hC3, 8'h00, 1'b0);
      @(negedge clk);
      tests++;
      if (b1.tx_start !== 1'b1) begin
         fails++; $display("FAIL mid_start: start=%b required 1", b1.tx_start);
      end
      rst_n = 1'b0;
      #1;
      tests++;
      if ({b1.in_ready, b1.enc_nibble, b1.tx_data, b1.tx_start, busy1, tmo1, cnt1} !== '0) begin
         fails++; $display("FAIL mid_outs: got %h required 0",
            {b1.in_ready, b1.enc_nibble, b1.tx_data, b1.tx_start, busy1, tmo1, cnt1});
      end
      @(negedge clk);
      rst_n = 1'b1;
      s = starts1;
      repeat (30) @(negedge clk);
      tests++;
      if (starts1 != s || b1.in_ready !== 1'b1 || cnt1 !== 16'd0) begin
         fails++; $display("FAIL mid_after: starts=%0d in_ready=%b byte_cnt=%0d required %0d/1/0",
            starts1, b1.in_ready, cnt1, s);
      end
      obs1.delete(); exp1.delete();
   endtask

   initial begin
      test_reset();
      test_basic_a5();
      test_high_first();
      test_wrap();
      test_busy_hold();
      test_back_to_back();
      test_random();
`ifdef HAMMING_ERR_INJ_EN
      test_inject();
`endif
      test_timeout();
      test_reset_mid();
      tests++;
      if (dbl1 != 0 || dbl0 != 0) begin
         fails++; $display("FAIL start_pulse: consecutive starts %0d/%0d required 0/0", dbl1, dbl0);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
